// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - timing-count encoding and instruction field positions
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    SC_T0   = 3'd0,
    SC_T1   = 3'd1,
    SC_T2   = 3'd2,
    SC_EXEC = 3'd3,
    SC_RT0  = 3'd4,
    SC_RT1  = 3'd5,
    SC_RT2  = 3'd6,
    SC_IDLE = 3'd7
  } sc_e;

  localparam int IR_I_BIT   = 15;
  localparam int IR_OP_HI   = 14;
  localparam int IR_OP_LO   = 12;
  localparam int IR_ADDR_HI = 11;
  localparam int IR_ADDR_LO = 0;
  localparam int OP_W       = IR_OP_HI - IR_OP_LO + 1;
  localparam int DEC_W      = 1 << OP_W;

  function automatic logic [OP_W-1:0] ir_opcode(input logic [15:0] ir);
    return ir[IR_OP_HI:IR_OP_LO];
  endfunction

endpackage

// File: rtl/fetch_sequencer_opcode_decoder_3to8.sv
// rtl/fetch_sequencer_opcode_decoder_3to8.sv - combinational 3-to-8 one-hot opcode decode
module opcode_decoder_3to8
  import fetch_sequencer_pkg::*;
(
  input  logic [OP_W-1:0]  opcode_i,
  output logic [DEC_W-1:0] onehot_o
);

  always_comb begin
    onehot_o           = '0;
    onehot_o[opcode_i] = 1'b1;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode timing controller feeding the execute unit
// Interrupt cycle (RT0..RT2) is built only when FETCH_SEQ_INTERRUPT_EN is defined.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic [WIDTH-1:0]  pc_value,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              exec_done,
  output logic              reset_pc,
  output logic              increment_pc,
  output logic              ar_load,
  output logic [WIDTH-1:0]  ar_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ir,
  output logic [7:0]        opcode_dec,
  output logic              ind,
  output logic [2:0]        sc,
  output logic              exec_valid,
  input  logic              ien,
  input  logic              fgi,
  input  logic              fgo,
  output logic              ien_clr
);

  sc_e               state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DEC_W-1:0]  dec_q, dec_d, dec_comb;
  logic              ind_q, ind_d;
  logic [WIDTH-1:0]  addr_field;

  logic              ar_load_c;
  logic [WIDTH-1:0]  ar_data_c;
  logic              mem_rd_c;
  logic              mem_wr_c;
  logic              inc_pc_c;
  logic              reset_pc_c;
  logic              ien_clr_c;
  logic              exec_valid_c;

`ifdef FETCH_SEQ_INTERRUPT_EN
  logic              r_q, r_d;
  logic [WIDTH-1:0]  tr_q, tr_d;
`else
  logic              unused_irq_inputs;
  assign unused_irq_inputs = ien ^ fgi ^ fgo;
`endif

  assign addr_field = WIDTH'(ir_q[IR_ADDR_HI:IR_ADDR_LO]);

  opcode_decoder_3to8 u_dec (
    .opcode_i (ir_opcode(ir_q)),
    .onehot_o (dec_comb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SC_IDLE;
      ir_q    <= '0;
      dec_q   <= '0;
      ind_q   <= 1'b0;
`ifdef FETCH_SEQ_INTERRUPT_EN
      r_q     <= 1'b0;
      tr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
      ind_q   <= ind_d;
`ifdef FETCH_SEQ_INTERRUPT_EN
      r_q     <= r_d;
      tr_q    <= tr_d;
`endif
    end
  end

  // Strobes decode from state only; the PC pulses in T1/RT1 alone follow mem_ready.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    dec_d        = dec_q;
    ind_d        = ind_q;
    ar_load_c    = 1'b0;
    ar_data_c    = '0;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;
    inc_pc_c     = 1'b0;
    reset_pc_c   = 1'b0;
    ien_clr_c    = 1'b0;
    exec_valid_c = 1'b0;
`ifdef FETCH_SEQ_INTERRUPT_EN
    r_d          = r_q;
    tr_d         = tr_q;
`endif
    case (state_q)
      SC_IDLE: begin
        if (start) state_d = SC_T0;
      end
      SC_T0: begin
        ar_load_c = 1'b1;
        ar_data_c = pc_value;
        state_d   = SC_T1;
      end
      SC_T1: begin
        mem_rd_c  = 1'b1;
        ar_data_c = pc_value;
        if (mem_ready) begin
          ir_d     = mem_rdata;
          inc_pc_c = 1'b1;
          state_d  = SC_T2;
        end
      end
      SC_T2: begin
        ar_load_c = 1'b1;
        ar_data_c = addr_field;
        dec_d     = dec_comb;
        ind_d     = ir_q[IR_I_BIT];
        state_d   = SC_EXEC;
      end
      SC_EXEC: begin
        exec_valid_c = 1'b1;
        ar_data_c    = addr_field;
`ifdef FETCH_SEQ_INTERRUPT_EN
        if (ien && (fgi || fgo)) r_d = 1'b1;
`endif
        if (exec_done) begin
          if (halt) state_d = SC_IDLE;
`ifdef FETCH_SEQ_INTERRUPT_EN
          else if (r_d) state_d = SC_RT0;
`endif
          else state_d = SC_T0;
        end
      end
`ifdef FETCH_SEQ_INTERRUPT_EN
      SC_RT0: begin
        ar_load_c = 1'b1;
        tr_d      = pc_value;
        state_d   = SC_RT1;
      end
      SC_RT1: begin
        mem_wr_c = 1'b1;
        if (mem_ready) begin
          reset_pc_c = 1'b1;
          state_d    = SC_RT2;
        end
      end
      SC_RT2: begin
        inc_pc_c  = 1'b1;
        ien_clr_c = 1'b1;
        r_d       = 1'b0;
        state_d   = SC_T0;
      end
`endif
      default: state_d = SC_IDLE;
    endcase
  end

  assign sc           = state_q;
  assign ir           = ir_q;
  assign opcode_dec   = dec_q;
  assign ind          = ind_q;
  assign ar_load      = ar_load_c;
  assign ar_data      = ar_data_c;
  assign mem_rd       = mem_rd_c;
  assign mem_wr       = mem_wr_c;
  assign increment_pc = inc_pc_c;
  assign reset_pc     = reset_pc_c;
  assign ien_clr      = ien_clr_c;
  assign exec_valid   = exec_valid_c;
`ifdef FETCH_SEQ_INTERRUPT_EN
  assign mem_wdata    = DATA_W'(tr_q);
`else
  assign mem_wdata    = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a program-level reference model
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [11:0] pc_value;
  logic [15:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        reset_pc, increment_pc, ar_load, mem_rd, mem_wr;
  logic [11:0] ar_data;
  logic [15:0] mem_wdata, ir;
  logic [7:0]  opcode_dec;
  logic        ind, exec_valid, ien_clr;
  logic [2:0]  sc;
  logic        ien = 1'b0, fgi = 1'b0, fgo = 1'b0;

  fetch_sequencer #(.WIDTH(12), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .pc_value(pc_value), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .exec_done(exec_done), .reset_pc(reset_pc), .increment_pc(increment_pc),
    .ar_load(ar_load), .ar_data(ar_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .ir(ir), .opcode_dec(opcode_dec), .ind(ind),
    .sc(sc), .exec_valid(exec_valid), .ien(ien), .fgi(fgi), .fgo(fgo),
    .ien_clr(ien_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] ir;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] irq_q[$];
  logic [15:0] ref_mem [0:4095];
  logic [11:0] pc_ref;
  int          tests = 0;
  int          fails = 0;
  int          rd_waits = 0;
  int          wr_waits = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // PC register environment
  logic [11:0] pc_q;
  logic        pc_set = 1'b0;
  logic [11:0] pc_set_val = 12'h0;
  always @(posedge clk) begin
    if (pc_set) pc_q <= pc_set_val;
    else if (reset_pc) pc_q <= 12'h0;
    else if (increment_pc) pc_q <= pc_q + 12'h1;
  end
  assign pc_value = pc_q;

  // Memory environment: address register plus array
  logic [15:0] mem [0:4095];
  logic [11:0] ar_q = 12'h0;
  assign mem_rdata = mem[ar_q];
  initial begin
    #1;
    for (int i = 0; i < 4096; i++) mem[i] = ref_mem[i];
    forever begin
      @(posedge clk);
      if (mem_wr && mem_ready) mem[ar_q] = mem_wdata;
      if (ar_load) ar_q = ar_data;
    end
  end

  // Memory responder: programmed wait states, random ready outside accesses
  initial begin
    int  waits_left;
    bit  busy;
    waits_left = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        if (!busy) begin
          busy = 1'b1;
          waits_left = mem_rd ? rd_waits : wr_waits;
        end
        if (waits_left > 0) begin
          mem_ready = 1'b0;
          waits_left--;
        end else begin
          mem_ready = 1'b1;
          busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard when the DUT presents a decoded instruction
  initial begin
    exp_t        cur;
    int          cyc, t0_cyc, rd_cnt, inc_cnt;
    logic [11:0] t0_addr, t2_addr, cur_ret;
    logic [15:0] last_ir;
    logic        prev_ev;
    cyc = 0; t0_cyc = 0; rd_cnt = 0; inc_cnt = 0;
    t0_addr = '0; t2_addr = '0; cur_ret = '0; last_ir = '0; prev_ev = 1'b0;
    cur.addr = '0; cur.ir = '0; cur.waits = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!reset_n) begin
        prev_ev = 1'b0;
      end else begin
        chk("pulse_excl", 32'(reset_pc & increment_pc), 32'd0);
        chk("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
        chk("exec_valid_decode", 32'(exec_valid), 32'(sc == 3'd3));
`ifndef FETCH_SEQ_INTERRUPT_EN
        chk("irq_outputs_tied", {28'd0, ien_clr, mem_wr, reset_pc, |mem_wdata}, 32'd0);
`endif
        if (sc == 3'd7)
          chk("idle_controls", 32'({ar_load, mem_rd, mem_wr, exec_valid, increment_pc, reset_pc, ien_clr}), 32'd0);
        if (sc == 3'd0) begin
          chk("t0_ar_load", 32'(ar_load), 32'd1);
          t0_addr = ar_data; t0_cyc = cyc; rd_cnt = 0; inc_cnt = 0; last_ir = ir;
        end
        if (sc == 3'd1) begin
          rd_cnt++;
          if (increment_pc) inc_cnt++;
          chk("t1_mem_rd", 32'(mem_rd), 32'd1);
          chk("t1_ar_held", 32'(ar_data), 32'(t0_addr));
          chk("t1_inc_on_ready", 32'(increment_pc), 32'(mem_ready));
          chk("t1_ir_held", 32'(ir), 32'(last_ir));
        end
        if (sc == 3'd2) begin
          chk("t2_ar_load", 32'(ar_load), 32'd1);
          t2_addr = ar_data;
        end
        if (exec_valid && !prev_ev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_exec_valid", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("t0_ar_data", 32'(t0_addr), 32'(cur.addr));
            chk("ir", 32'(ir), 32'(cur.ir));
            chk("opcode_dec", 32'(opcode_dec), 32'(8'd1 << cur.ir[14:12]));
            chk("ind", 32'(ind), 32'(cur.ir[15]));
            chk("t2_ar_data", 32'(t2_addr), 32'(cur.ir[11:0]));
            chk("latency", 32'(cyc - t0_cyc), 32'(3 + cur.waits));
            chk("mem_rd_cycles", 32'(rd_cnt), 32'(cur.waits + 1));
            chk("increment_count", 32'(inc_cnt), 32'd1);
          end
        end else if (exec_valid) begin
          chk("exec_ir_stable", {ind, opcode_dec, 7'd0, ir}, {cur.ir[15], 8'd1 << cur.ir[14:12], 7'd0, cur.ir});
        end
`ifdef FETCH_SEQ_INTERRUPT_EN
        if (sc != 3'd6) chk("ien_clr_idle", 32'(ien_clr), 32'd0);
        if (sc == 3'd4) begin
          chk("rt0_ar", 32'({ar_load, ar_data}), 32'({1'b1, 12'h000}));
          if (irq_q.size() == 0) chk("unexpected_rt0", 32'd1, 32'd0);
          else cur_ret = irq_q.pop_front();
        end
        if (sc == 3'd5) begin
          chk("rt1_mem_wr", 32'(mem_wr), 32'd1);
          chk("rt1_mem_wdata", 32'(mem_wdata), 32'({4'h0, cur_ret}));
          chk("rt1_reset_pc", 32'(reset_pc), 32'(mem_ready));
        end
        if (sc == 3'd6)
          chk("rt2_pulses", 32'({increment_pc, ien_clr}), 32'd3);
`endif
        prev_ev = exec_valid;
      end
    end
  end

  task automatic run_instr(input int waits, input bit do_halt, input bit irq, input int delay);
    exp_t e;
    int   n;
    rd_waits = waits;
    e.addr = pc_ref; e.ir = ref_mem[pc_ref]; e.waits = waits;
    exp_q.push_back(e);
    pc_ref = pc_ref + 12'h1;
    if (sc == 3'd7) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!exec_valid && n < 100) begin
      exec_done = 1'($urandom_range(0, 1));
      halt      = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1)); fgi = 1'($urandom_range(0, 1)); fgo = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    exec_done = 1'b0; halt = 1'b0; start = 1'b0;
    if (!exec_valid) begin
      chk("exec_valid_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i <= delay; i++) begin
`ifdef FETCH_SEQ_INTERRUPT_EN
      ien = irq; fgi = 1'($urandom_range(0, 1)); fgo = irq & ~fgi;
`else
      ien = 1'($urandom_range(0, 1)); fgi = 1'($urandom_range(0, 1)); fgo = 1'($urandom_range(0, 1));
`endif
      if (i == delay) begin
        exec_done = 1'b1; halt = do_halt; start = 1'b0;
      end else begin
        halt = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    exec_done = 1'b0; halt = 1'b0; start = 1'b0; ien = 1'b0; fgi = 1'b0; fgo = 1'b0;
    if (do_halt) begin
      #1;
      chk("halt_to_idle", 32'(sc), 32'd7);
    end else if (irq) begin
      irq_q.push_back(pc_ref);
      ref_mem[0] = {4'h0, pc_ref};
      pc_ref = 12'h001;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'($urandom);
    ref_mem[12'h010] = 16'h7800;
    ref_mem[12'h011] = 16'h9123;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_sc", 32'(sc), 32'd7);
    chk("reset_regs", {ir, opcode_dec, 7'd0, ind}, 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_strobes", 32'({reset_pc, increment_pc, ar_load, mem_rd, mem_wr, exec_valid, ien_clr}), 32'd0);
    @(negedge clk);
    pc_set = 1'b1; pc_set_val = 12'h010;
    @(negedge clk);
    pc_set = 1'b0;
    reset_n = 1'b1;
    pc_ref = 12'h010;

    run_instr(0, 1'b0, 1'b0, 1);
    run_instr(4, 1'b1, 1'b0, 2);
    run_instr(1, 1'b0, 1'b0, 0);
    run_instr(0, 1'b1, 1'b0, 0);

`ifdef FETCH_SEQ_INTERRUPT_EN
    @(negedge clk);
    pc_set = 1'b1; pc_set_val = 12'h044;
    @(negedge clk);
    pc_set = 1'b0;
    pc_ref = 12'h044;
    wr_waits = 1;
    run_instr(0, 1'b0, 1'b1, 1);
    run_instr(0, 1'b1, 1'b0, 0);
`endif

    @(negedge clk);
    rd_waits = 30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_in_t1", 32'(sc), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_sc", 32'(sc), 32'd7);
    chk("async_reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("async_reset_ir", 32'(ir), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_waits = 0;

    for (int k = 0; k < 40; k++) begin
      bit h, q;
      h = ($urandom_range(0, 7) == 0);
`ifdef FETCH_SEQ_INTERRUPT_EN
      q = ($urandom_range(0, 3) == 0);
`else
      q = 1'b0;
`endif
      wr_waits = $urandom_range(0, 2);
      run_instr($urandom_range(0, 5), h, q, $urandom_range(0, 3));
    end
    run_instr(0, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size() + irq_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
